// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and defaults for the hazard/stall controller
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2
    } state_t;

    localparam int CNT_W               = 16;
    localparam int DEF_LOAD_USE_STALLS = 1;
    localparam int DEF_MAX_WAIT        = 64;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline stall/flush/freeze controller
// Load-use bubbles, branch/jump squash and data-memory wait freeze with timeout.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int LOAD_USE_STALLS = DEF_LOAD_USE_STALLS,
    parameter int MAX_WAIT        = DEF_MAX_WAIT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IF_ID_RSaddr_i,
    input  logic [4:0]       IF_ID_RTaddr_i,
    input  logic [4:0]       ID_EX_RTaddr_i,
    input  logic             ID_EX_MemRead_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    output logic             PC_write_o,
    output logic             IF_ID_write_o,
    output logic             IF_ID_flush_o,
    output logic             ID_EX_flush_o,
    output logic             pipe_freeze_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [2:0] STALL_REM = 3'(LOAD_USE_STALLS - 1);
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t     state_q, state_d, saved_q, saved_d, eff_state;
    logic [2:0] rem_q, rem_d;
    logic [7:0] wait_q, wait_d;
    logic       timeout_q, timeout_d;
    logic       freeze, hazard;

    assign freeze = dmem_req_i & ~dmem_ack_i;
    assign hazard = ID_EX_MemRead_i && (ID_EX_RTaddr_i != 5'd0) &&
                    ((ID_EX_RTaddr_i == IF_ID_RSaddr_i) || (ID_EX_RTaddr_i == IF_ID_RTaddr_i));

    // The ack cycle already behaves as the pre-wait state so a pending hazard is not lost.
    assign eff_state = (state_q == ST_MEM_WAIT) ? saved_q : state_q;

    always_comb begin
        state_d       = state_q;
        saved_d       = saved_q;
        rem_d         = rem_q;
        wait_d        = wait_q;
        timeout_d     = timeout_q;
        PC_write_o    = 1'b1;
        IF_ID_write_o = 1'b1;
        IF_ID_flush_o = 1'b0;
        ID_EX_flush_o = 1'b0;
        pipe_freeze_o = 1'b0;
        if (freeze) begin
            PC_write_o    = 1'b0;
            IF_ID_write_o = 1'b0;
            pipe_freeze_o = 1'b1;
            state_d       = ST_MEM_WAIT;
            saved_d       = eff_state;
            if (wait_q != 8'hFF) begin
                wait_d = wait_q + 8'd1;
            end
            if (wait_q >= WAIT_LAST) begin
                timeout_d = 1'b1;
            end
        end else begin
            wait_d  = 8'd0;
            state_d = eff_state;
            case (eff_state)
                ST_LOAD_STALL: begin
                    PC_write_o    = 1'b0;
                    IF_ID_write_o = 1'b0;
                    ID_EX_flush_o = 1'b1;
                    if (rem_q <= 3'd1) begin
                        rem_d   = 3'd0;
                        state_d = ST_RUN;
                    end else begin
                        rem_d = rem_q - 3'd1;
                    end
                end
                default: begin
                    if (hazard) begin
                        PC_write_o    = 1'b0;
                        IF_ID_write_o = 1'b0;
                        ID_EX_flush_o = 1'b1;
                        if (LOAD_USE_STALLS > 1) begin
                            state_d = ST_LOAD_STALL;
                            rem_d   = STALL_REM;
                        end
                    end else if (branch_taken_i || jump_i) begin
                        IF_ID_flush_o = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_RUN;
            saved_q   <= ST_RUN;
            rem_q     <= 3'd0;
            wait_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            saved_q   <= saved_d;
            rem_q     <= rem_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign mem_timeout_o = timeout_q;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk_i),
        .clr   (rst_i),
        .inc   (~PC_write_o),
        .count (stall_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk_i),
        .clr   (rst_i),
        .inc   (IF_ID_flush_o),
        .count (flush_cnt_o)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - scoreboard bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rs = '0, rt = '0, exrt = '0;
    logic       mr = 1'b0, br = 1'b0, jp = 1'b0, req = 1'b0, ack = 1'b0;

    logic        a_pcw, a_ifw, a_iff, a_idf, a_frz, a_to;
    logic        b_pcw, b_ifw, b_iff, b_idf, b_frz, b_to;
    logic [15:0] a_sc, a_fc, b_sc, b_fc;

    typedef struct {
        int          tag;
        int          dut;
        logic [5:0]  ctl;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   tag     = 0;

    // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, freeze, timeout}
    localparam logic [5:0] IDLE = 6'b110000;
    localparam logic [5:0] BUBL = 6'b000100;
    localparam logic [5:0] FLSH = 6'b111000;
    localparam logic [5:0] FRZ  = 6'b000010;

    always #5 clk = ~clk;

    hazard_stall_ctrl dut_a (
        .clk_i(clk), .rst_i(rst),
        .IF_ID_RSaddr_i(rs), .IF_ID_RTaddr_i(rt), .ID_EX_RTaddr_i(exrt),
        .ID_EX_MemRead_i(mr), .branch_taken_i(br), .jump_i(jp),
        .dmem_req_i(req), .dmem_ack_i(ack),
        .PC_write_o(a_pcw), .IF_ID_write_o(a_ifw), .IF_ID_flush_o(a_iff),
        .ID_EX_flush_o(a_idf), .pipe_freeze_o(a_frz), .mem_timeout_o(a_to),
        .stall_cnt_o(a_sc), .flush_cnt_o(a_fc)
    );

    hazard_stall_ctrl #(.LOAD_USE_STALLS(3), .MAX_WAIT(4)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .IF_ID_RSaddr_i(rs), .IF_ID_RTaddr_i(rt), .ID_EX_RTaddr_i(exrt),
        .ID_EX_MemRead_i(mr), .branch_taken_i(br), .jump_i(jp),
        .dmem_req_i(req), .dmem_ack_i(ack),
        .PC_write_o(b_pcw), .IF_ID_write_o(b_ifw), .IF_ID_flush_o(b_iff),
        .ID_EX_flush_o(b_idf), .pipe_freeze_o(b_frz), .mem_timeout_o(b_to),
        .stall_cnt_o(b_sc), .flush_cnt_o(b_fc)
    );

    task automatic drive(input logic r, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] e, input logic m, input logic b,
                         input logic j, input logic rq, input logic ak);
        @(posedge clk);
        #1;
        rst = r; rs = s; rt = t; exrt = e; mr = m; br = b; jp = j; req = rq; ack = ak;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_out(input int d, input logic [5:0] c, input int s, input int f);
        exp_t e;
        tag++;
        e.tag = tag; e.dut = d; e.ctl = c; e.sc = 16'(s); e.fc = 16'(f);
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [5:0]  act_ctl;
            logic [15:0] act_sc, act_fc;
            e = q.pop_front();
            if (e.dut == 0) begin
                act_ctl = {a_pcw, a_ifw, a_iff, a_idf, a_frz, a_to};
                act_sc = a_sc; act_fc = a_fc;
            end else begin
                act_ctl = {b_pcw, b_ifw, b_iff, b_idf, b_frz, b_to};
                act_sc = b_sc; act_fc = b_fc;
            end
            n_tests++;
            if (act_ctl !== e.ctl || act_sc !== e.sc || act_fc !== e.fc) begin
                n_fail++;
                $display("FAIL chk%0d dut%0d: ctl=%b sc=%0d fc=%0d, required ctl=%b sc=%0d fc=%0d",
                         e.tag, e.dut, act_ctl, act_sc, act_fc, e.ctl, e.sc, e.fc);
            end
        end
    end

    initial begin
        do_reset();
        do_reset();

        // reset state, then single load-use bubble (A) vs three bubbles (B)
        idle();                                   expect_out(0, IDLE, 0, 0); expect_out(1, IDLE, 0, 0);
        drive(0, 5'd5, 5'd0, 5'd5, 1, 0, 0, 0, 0); expect_out(0, BUBL, 0, 0); expect_out(1, BUBL, 0, 0);
        idle();                                   expect_out(0, IDLE, 1, 0); expect_out(1, BUBL, 1, 0);
        idle();                                   expect_out(0, IDLE, 1, 0); expect_out(1, BUBL, 2, 0);
        idle();                                   expect_out(0, IDLE, 1, 0); expect_out(1, IDLE, 3, 0);

        // load to $0 never stalls; branch and jump squash; branch under hazard deferred
        do_reset();
        drive(0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0); expect_out(0, IDLE, 0, 0); expect_out(1, IDLE, 0, 0);
        drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0); expect_out(0, FLSH, 0, 0);
        idle();                                   expect_out(0, IDLE, 0, 1);
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0); expect_out(1, FLSH, 0, 1);
        idle();                                   expect_out(0, IDLE, 0, 2);
        drive(0, 5'd1, 5'd7, 5'd7, 1, 1, 0, 0, 0); expect_out(0, BUBL, 0, 2); expect_out(1, BUBL, 0, 2);
        drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0); expect_out(0, FLSH, 1, 2); expect_out(1, BUBL, 1, 2);
        idle();                                   expect_out(0, IDLE, 1, 3); expect_out(1, BUBL, 2, 2);
        idle();                                   expect_out(1, IDLE, 3, 2);

        // 10-cycle memory wait with hazard pending, then the bubble on ack
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(0, 5'd5, 5'd0, 5'd5, 1, 0, 0, 1, 0);
            expect_out(0, FRZ, k, 0);
            expect_out(1, (k >= 4) ? (FRZ | 6'b000001) : FRZ, k, 0);
        end
        drive(0, 5'd5, 5'd0, 5'd5, 1, 0, 0, 1, 1); expect_out(0, BUBL, 10, 0); expect_out(1, 6'b000101, 10, 0);
        idle();                                   expect_out(0, IDLE, 11, 0);

        // timeout with MAX_WAIT=4, sticky until reset
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
            expect_out(1, (k >= 4) ? (FRZ | 6'b000001) : FRZ, k, 0);
        end
        idle();                                   expect_out(1, IDLE | 6'b000001, 6, 0); expect_out(0, IDLE, 6, 0);
        idle();                                   expect_out(1, IDLE | 6'b000001, 6, 0);
        do_reset();
        idle();                                   expect_out(1, IDLE, 0, 0); expect_out(0, IDLE, 0, 0);

        // reset in the middle of LOAD_STALL
        drive(0, 5'd9, 5'd0, 5'd9, 1, 0, 0, 0, 0); expect_out(1, BUBL, 0, 0);
        do_reset();
        idle();                                   expect_out(1, IDLE, 0, 0);

        repeat (2) @(posedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 Parameter LOAD_USE_STALLS, default 1: bubble cycles inserted per load-use hazard, legal range 1..7.
REQ-002 Parameter MAX_WAIT, default 64: data-memory wait cycles before timeout is flagged, legal range 2..255.
REQ-003 Port clk_i  in  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_i  in  1  reset; synchronous, active-high.
REQ-005 Port IF_ID_RSaddr_i  in  5  rs of the instruction in ID.
REQ-006 Port IF_ID_RTaddr_i  in  5  rt of the instruction in ID.
REQ-007 Port ID_EX_RTaddr_i  in  5  load destination in EX.
REQ-008 Port ID_EX_MemRead_i  in  1  instruction in EX is a load.
REQ-009 Port branch_taken_i  in  1  branch resolved taken in ID.
REQ-010 Port jump_i  in  1  jump decoded in ID.
REQ-011 Port dmem_req_i  in  1  MEM-stage access pending; held high until ack.
REQ-012 Port dmem_ack_i  in  1  data memory completes the access this cycle.
REQ-013 Port PC_write_o  out  1  PC update enable.
REQ-014 Port IF_ID_write_o  out  1  IF/ID register load enable.
REQ-015 Port IF_ID_flush_o  out  1  zero IF/ID (squash fetched instruction).
REQ-016 Port ID_EX_flush_o  out  1  zero ID/EX control bits (insert bubble).
REQ-017 Port pipe_freeze_o  out  1  hold every pipeline register.
REQ-018 Port mem_timeout_o  out  1  sticky: wait exceeded MAX_WAIT.
REQ-019 Port stall_cnt_o  out  16  saturating count of stall cycles.
REQ-020 Port flush_cnt_o  out  16  saturating count of IF/ID flushes.

Function
REQ-021 States: RUN, LOAD_STALL, MEM_WAIT; outputs combinational from state and inputs.
REQ-022 Freeze condition F = dmem_req_i & ~dmem_ack_i, in any state.
REQ-023 When F is true: pipe_freeze_o=1, PC_write_o=0, IF_ID_write_o=0, both flushes 0, state -> MEM_WAIT; state and bubble count are otherwise held.
REQ-024 MEM_WAIT: wait counter increments each F cycle.
- When the counter reaches MAX_WAIT, mem_timeout_o is set and stays set until reset.
- On ack (F false), the state returns to the pre-wait state (RUN or LOAD_STALL) and the wait counter clears.
REQ-025 Load-use condition H = ID_EX_MemRead_i & (ID_EX_RTaddr_i != 0) & (ID_EX_RTaddr_i == IF_ID_RSaddr_i | ID_EX_RTaddr_i == IF_ID_RTaddr_i).
REQ-026 In RUN with ~F and H: PC_write_o=0, IF_ID_write_o=0, ID_EX_flush_o=1, IF_ID_flush_o=0.
- If LOAD_USE_STALLS>1, state -> LOAD_STALL with remaining count LOAD_USE_STALLS-1; otherwise stay in RUN.
REQ-027 LOAD_STALL with ~F: same outputs as REQ-026; remaining count decrements each cycle and the state returns to RUN after the cycle in which the count reaches 0.
REQ-028 In RUN with ~F, ~H, and (branch_taken_i | jump_i): IF_ID_flush_o=1, PC_write_o=1, IF_ID_write_o=1.
REQ-029 Priority: freeze > load-use stall > branch/jump flush; a branch coincident with H is ignored that cycle and is re-evaluated after the stall.
REQ-030 Idle (RUN, ~F, ~H, no branch): PC_write_o=1, IF_ID_write_o=1, every other control output 0.
REQ-031 stall_cnt_o increments on every cycle with PC_write_o=0; flush_cnt_o increments on every cycle with IF_ID_flush_o=1; both saturate at 16'hFFFF.

Reset
REQ-032 rst_i high at a rising edge forces state RUN, all counters 0, and mem_timeout_o 0, overriding every other input, including mid-MEM_WAIT and mid-LOAD_STALL.
REQ-033 In the cycle after reset with idle inputs: PC_write_o=1, IF_ID_write_o=1, every other output 0.

Structure
REQ-034 Package hazard_pkg holds the state encoding, the 16-bit counter width, and the LOAD_USE_STALLS/MAX_WAIT defaults.
REQ-035 One sub-module, sat_counter (width-parameterised, with inc and clr inputs), is instantiated for stall_cnt_o and flush_cnt_o.

Verification
REQ-036 Idle -> load to $5 in EX, ID rs=$5 -> exactly 1 cycle with PC_write_o=0 and ID_EX_flush_o=1; stall_cnt_o=1.
REQ-037 LOAD_USE_STALLS=3, same hazard -> 3 consecutive bubble cycles; return to RUN; stall_cnt_o=3.
REQ-038 Load to $0 with ID rs=$0 -> no stall; branch_taken_i pulse -> IF_ID_flush_o=1 for 1 cycle; flush_cnt_o=1.
REQ-039 dmem_req_i held, ack after 10 cycles, hazard present during the wait -> freeze for 10 cycles with no flush, then the 1-cycle load-use bubble.
REQ-040 MAX_WAIT=4 with no ack for 6 cycles -> mem_timeout_o rises after the 4th wait cycle and stays set; rst_i pulse clears it and all counters.
